// File: rtl/seven_seg_scan.sv
// Four-digit time-multiplexed seven-segment driver for a common-anode display.
// Latency: every output is registered, one cycle behind the scan state.
// Backpressure: none; the scan free-runs and digit data is sampled once per frame.
//
// Ports:
//   clock_100Mhz  system clock
//   reset         asynchronous, active-high
//   digits_bcd    packed BCD digits, [3:0] = digit 0 (rightmost)
//   dp_mask       decimal point request per digit, active-high
//   lz_blank_en   leading-zero blanking enable
//   anode         digit enables, active-low, anode[0] = rightmost digit
//   seg           segments {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low
//   frame_tick    one-cycle pulse at the start of each frame
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [15:0] digits_bcd,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank_en,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shd;
  logic [3:0]    shdp;
  logic          shd_lz;

  logic          frame_start;
  logic          blank_phase;
  logic [3:0]    nibble;
  logic          dp_req;
  logic          lz_hide;
  logic          z3;
  logic          z32;
  logic          z321;
  logic [3:0]    anode_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign frame_start = (cnt == '0) && (idx == 2'd0);
  assign blank_phase = (cnt < BLANK_END);

  // Running "all zero from the left" flags: a digit is a leading zero only
  // if it and every digit to its left are zero. Dash nibbles count as nonzero.
  assign z3   = (shd[15:12] == 4'd0);
  assign z32  = z3  && (shd[11:8] == 4'd0);
  assign z321 = z32 && (shd[7:4]  == 4'd0);

  always_comb begin
    nibble  = shd[3:0];
    dp_req  = shdp[0];
    lz_hide = 1'b0;
    case (idx)
      2'd0: begin nibble = shd[3:0];   dp_req = shdp[0]; lz_hide = 1'b0; end
      2'd1: begin nibble = shd[7:4];   dp_req = shdp[1]; lz_hide = z321; end
      2'd2: begin nibble = shd[11:8];  dp_req = shdp[2]; lz_hide = z32;  end
      default: begin nibble = shd[15:12]; dp_req = shdp[3]; lz_hide = z3; end
    endcase
  end

  always_comb begin
    anode_nxt = 4'b1111;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    if (!blank_phase) begin
      anode_nxt      = 4'b1111;
      anode_nxt[idx] = 1'b0;
      // Blanked leading zeros keep their anode so the brightness duty of the
      // remaining digits does not change with the value shown.
      seg_nxt        = (shd_lz && lz_hide) ? SEG_OFF : bcd_to_seg(nibble);
      dp_nxt         = ~dp_req;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shd        <= 16'd0;
      shdp       <= 4'd0;
      shd_lz     <= 1'b0;
      anode      <= 4'b1111;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Whole-frame snapshot so a counter update mid-frame cannot tear.
      if (frame_start) begin
        shd    <= digits_bcd;
        shdp   <= dp_mask;
        shd_lz <= lz_blank_en;
      end

      anode      <= anode_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  logic        clock_100Mhz;
  logic        reset;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_mask;
  logic        lz_blank_en;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int total;
  int bad;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SDSH = 7'b0111111;
  localparam logic [6:0] SOFF = 7'b1111111;

  seven_seg_scan #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .digits_bcd  (digits_bcd),
    .dp_mask     (dp_mask),
    .lz_blank_en (lz_blank_en),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .frame_tick  (frame_tick)
  );

  initial clock_100Mhz = 1'b0;
  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic tick();
    @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
  endtask

  // Steps through one digit slot (ncyc cycles, 8 for a full slot) and checks
  // every cycle: 2 blank cycles, then the active digit. Optionally changes
  // digits_bcd after cycle chg_cyc to probe frame sampling.
  task automatic run_slot(input string name, input int slot_idx,
                          input logic [6:0] exp_seg, input logic exp_dp,
                          input int chg_cyc, input logic [15:0] chg_val,
                          input int ncyc);
    logic [3:0] exp_an;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      exp_an = 4'b1111;
      if (c >= 2) exp_an[slot_idx] = 1'b0;
      chk($sformatf("%s slot%0d c%0d anode", name, slot_idx, c), 16'(anode), 16'(exp_an));
      chk($sformatf("%s slot%0d c%0d seg", name, slot_idx, c), 16'(seg),
          16'((c >= 2) ? exp_seg : SOFF));
      chk($sformatf("%s slot%0d c%0d dp", name, slot_idx, c), 16'(dp),
          16'((c >= 2) ? exp_dp : 1'b1));
      chk($sformatf("%s slot%0d c%0d frame_tick", name, slot_idx, c), 16'(frame_tick),
          16'((c == 0 && slot_idx == 0) ? 1'b1 : 1'b0));
      if (c == chg_cyc) digits_bcd = chg_val;
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    digits_bcd  = 16'h1234;
    dp_mask     = 4'b0000;
    lz_blank_en = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("reset anode", 16'(anode), 16'h000F);
    chk("reset seg", 16'(seg), 16'h007F);
    chk("reset dp", 16'(dp), 16'h0001);
    chk("reset frame_tick", 16'(frame_tick), 16'h0000);

    // Scan order: 1234 shows 4,3,2,1 on digits 0..3; frame_tick every 32 cycles.
    reset = 1'b0;
    run_slot("scan", 0, S4, 1'b1, -1, 16'h0, 8);
    run_slot("scan", 1, S3, 1'b1, -1, 16'h0, 8);
    run_slot("scan", 2, S2, 1'b1, -1, 16'h0, 8);
    run_slot("scan", 3, S1, 1'b1, -1, 16'h0, 8);

    // Frame sampling: 0009 is loaded, 0010 arrives mid slot 2 and waits.
    digits_bcd = 16'h0009;
    run_slot("samp_a", 0, S9, 1'b1, -1, 16'h0, 8);
    run_slot("samp_a", 1, S0, 1'b1, -1, 16'h0, 8);
    run_slot("samp_a", 2, S0, 1'b1, 3, 16'h0010, 8);
    run_slot("samp_a", 3, S0, 1'b1, -1, 16'h0, 8);
    run_slot("samp_b", 0, S0, 1'b1, -1, 16'h0, 8);
    run_slot("samp_b", 1, S1, 1'b1, -1, 16'h0, 8);
    run_slot("samp_b", 2, S0, 1'b1, -1, 16'h0, 8);
    run_slot("samp_b", 3, S0, 1'b1, -1, 16'h0, 8);

    // Leading-zero blanking on 0070.
    digits_bcd  = 16'h0070;
    lz_blank_en = 1'b1;
    run_slot("lz70", 0, S0, 1'b1, -1, 16'h0, 8);
    run_slot("lz70", 1, S7, 1'b1, -1, 16'h0, 8);
    run_slot("lz70", 2, SOFF, 1'b1, -1, 16'h0, 8);
    run_slot("lz70", 3, SOFF, 1'b1, -1, 16'h0, 8);

    // All zero: only digit 0 lit.
    digits_bcd = 16'h0000;
    run_slot("lz00", 0, S0, 1'b1, -1, 16'h0, 8);
    run_slot("lz00", 1, SOFF, 1'b1, -1, 16'h0, 8);
    run_slot("lz00", 2, SOFF, 1'b1, -1, 16'h0, 8);
    run_slot("lz00", 3, SOFF, 1'b1, -1, 16'h0, 8);

    // Dash counts as nonzero; dp passes through blanking logic untouched.
    digits_bcd = 16'h00A5;
    dp_mask    = 4'b0010;
    run_slot("dash", 0, S5, 1'b1, -1, 16'h0, 8);
    run_slot("dash", 1, SDSH, 1'b0, -1, 16'h0, 8);
    run_slot("dash", 2, SOFF, 1'b1, -1, 16'h0, 8);
    run_slot("dash", 3, SOFF, 1'b1, -1, 16'h0, 8);

    // Mid-slot asynchronous reset during slot 2's drive phase.
    run_slot("mid", 0, S5, 1'b1, -1, 16'h0, 8);
    run_slot("mid", 1, SDSH, 1'b0, -1, 16'h0, 8);
    run_slot("mid", 2, SOFF, 1'b1, -1, 16'h0, 4);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst anode", 16'(anode), 16'h000F);
    chk("midrst seg", 16'(seg), 16'h007F);
    chk("midrst dp", 16'(dp), 16'h0001);
    chk("midrst frame_tick", 16'(frame_tick), 16'h0000);
    tick();
    reset = 1'b0;
    run_slot("rst_rel", 0, S5, 1'b1, -1, 16'h0, 8);
    run_slot("rst_rel", 1, SDSH, 1'b0, -1, 16'h0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
